// File: rtl/instr_fetch_unit.sv
// Fetches one little-endian 16-bit instruction from byte-wide memory into a
// single-entry buffer with a valid/ready handshake, flush and wait timeout.
module instr_fetch_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [15:0] pc_in,
   input  logic        fetch_req_in,
   input  logic        flush_in,
   output logic [15:0] mem_addr_out,
   output logic        mem_rd_req_out,
   input  logic        mem_ack_in,
   input  logic [7:0]  mem_rdata_in,
   output logic [15:0] instr_out,
   output logic [15:0] instr_pc_out,
   output logic        instr_valid_out,
   input  logic        instr_ready_in,
   output logic        busy_out,
   output logic        fetch_err_out
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, VALID} state_t;

   state_t          state;
   logic [14:0]     addr_q;
   logic [15:0]     instr_q;
   logic [15:0]     mem_addr_q;
   logic [CW-1:0]   cnt;
   logic            err_q;
   logic            in_fetch;
   logic            timed_out;
   logic            pc_unused;

   assign pc_unused = pc_in[0];

   assign in_fetch  = (state == FETCH_LO) || (state == FETCH_HI);
   // An ack in the limit cycle wins over the abort.
   assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT)) && !mem_ack_in;

   assign mem_rd_req_out  = in_fetch;
   assign mem_addr_out    = mem_addr_q;
   assign instr_out       = instr_q;
   assign instr_pc_out    = {addr_q, 1'b0};
   assign instr_valid_out = (state == VALID);
   assign busy_out        = (state != IDLE);
   assign fetch_err_out   = err_q;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state      <= IDLE;
         addr_q     <= '0;
         instr_q    <= '0;
         mem_addr_q <= '0;
         cnt        <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (flush_in) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (fetch_req_in) begin
                     addr_q     <= pc_in[15:1];
                     mem_addr_q <= {pc_in[15:1], 1'b0};
                     cnt        <= '0;
                     state      <= FETCH_LO;
                  end
               end
               FETCH_LO: begin
                  if (mem_ack_in) begin
                     instr_q[7:0] <= mem_rdata_in;
                     mem_addr_q   <= {addr_q, 1'b1};
                     cnt          <= '0;
                     state        <= FETCH_HI;
                  end else if (timed_out) begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               FETCH_HI: begin
                  if (mem_ack_in) begin
                     instr_q[15:8] <= mem_rdata_in;
                     state         <= VALID;
                  end else if (timed_out) begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               VALID: begin
                  // Back-to-back fetch skips IDLE to sustain one instruction per 3 cycles.
                  if (instr_ready_in) begin
                     if (fetch_req_in) begin
                        addr_q     <= pc_in[15:1];
                        mem_addr_q <= {pc_in[15:1], 1'b0};
                        cnt        <= '0;
                        state      <= FETCH_LO;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a configurable-wait byte memory.
module tb_instr_fetch_unit;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic [15:0] pc_in;
   logic        fetch_req_in;
   logic        flush_in;
   logic [15:0] mem_addr_out;
   logic        mem_rd_req_out;
   logic        mem_ack_in;
   logic [7:0]  mem_rdata_in;
   logic [15:0] instr_out;
   logic [15:0] instr_pc_out;
   logic        instr_valid_out;
   logic        instr_ready_in;
   logic        busy_out;
   logic        fetch_err_out;

   int tests = 0;
   int fails = 0;

   // memory model: ack after wait_cfg wait cycles, or never when no_ack
   logic [7:0] mem [16];
   int         wait_cfg;
   logic       no_ack;
   int         wcnt;

   instr_fetch_unit #(.TIMEOUT(3)) dut (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .pc_in           (pc_in),
      .fetch_req_in    (fetch_req_in),
      .flush_in        (flush_in),
      .mem_addr_out    (mem_addr_out),
      .mem_rd_req_out  (mem_rd_req_out),
      .mem_ack_in      (mem_ack_in),
      .mem_rdata_in    (mem_rdata_in),
      .instr_out       (instr_out),
      .instr_pc_out    (instr_pc_out),
      .instr_valid_out (instr_valid_out),
      .instr_ready_in  (instr_ready_in),
      .busy_out        (busy_out),
      .fetch_err_out   (fetch_err_out)
   );

   always #5 clk_in = ~clk_in;

   assign mem_ack_in   = mem_rd_req_out && !no_ack && (wcnt == wait_cfg);
   assign mem_rdata_in = mem[mem_addr_out[3:0]];

   always @(posedge clk_in) begin
      if (!mem_rd_req_out || mem_ack_in) wcnt <= 0;
      else                               wcnt <= wcnt + 1;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[4'h4] = 8'h34;  mem[4'h5] = 8'h12;
      mem[4'h6] = 8'h78;  mem[4'h7] = 8'h56;
      wcnt = 0;  wait_cfg = 0;  no_ack = 1'b0;
      pc_in = 16'h0000;  fetch_req_in = 1'b0;  flush_in = 1'b0;  instr_ready_in = 1'b0;
      reset_in = 1'b1;
      #1;
      check("rst_addr",  mem_addr_out, 16'h0000);
      check("rst_req",   {15'd0, mem_rd_req_out}, 16'd0);
      check("rst_instr", instr_out, 16'h0000);
      check("rst_pc",    instr_pc_out, 16'h0000);
      check("rst_ctl",   {13'd0, instr_valid_out, busy_out, fetch_err_out}, 16'd0);
      tick(); tick();
      reset_in = 1'b0;
      tick();

      // zero-wait fetch of 0x0124
      pc_in = 16'h0124;  fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      check("t1_req_c1",  {15'd0, mem_rd_req_out}, 16'd1);
      check("t1_addr_c1", mem_addr_out, 16'h0124);
      tick();
      check("t1_addr_c2", mem_addr_out, 16'h0125);
      check("t1_valid_c2", {15'd0, instr_valid_out}, 16'd0);
      tick();
      check("t1_valid_c3", {15'd0, instr_valid_out}, 16'd1);
      check("t1_instr", instr_out, 16'h1234);
      check("t1_pc",    instr_pc_out, 16'h0124);
      check("t1_req_c3", {15'd0, mem_rd_req_out}, 16'd0);
      instr_ready_in = 1'b1;
      tick();
      instr_ready_in = 1'b0;
      check("t1_idle", {14'd0, instr_valid_out, busy_out}, 16'd0);
      check("t1_addr_hold", mem_addr_out, 16'h0125);

      // odd pc: bit 0 ignored
      pc_in = 16'h0125;  fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      check("t2_addr_lo", mem_addr_out, 16'h0124);
      tick();
      check("t2_addr_hi", mem_addr_out, 16'h0125);
      tick();
      check("t2_pc",    instr_pc_out, 16'h0124);
      check("t2_instr", instr_out, 16'h1234);

      // 2 wait cycles per byte, decoder stalls 5 cycles, then back-to-back
      instr_ready_in = 1'b1;
      tick();
      instr_ready_in = 1'b0;
      wait_cfg = 2;
      pc_in = 16'h0124;  fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         check($sformatf("t3_req_c%0d", c), {15'd0, mem_rd_req_out}, 16'd1);
         check($sformatf("t3_addr_c%0d", c), mem_addr_out, (c <= 3) ? 16'h0124 : 16'h0125);
         check($sformatf("t3_nv_c%0d", c), {15'd0, instr_valid_out}, 16'd0);
         tick();
      end
      check("t3_valid_c7", {15'd0, instr_valid_out}, 16'd1);
      check("t3_instr", instr_out, 16'h1234);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t4_hold_%0d", c), {instr_valid_out, instr_out[14:0]}, 16'h9234);
      end
      wait_cfg = 0;
      instr_ready_in = 1'b1;  fetch_req_in = 1'b1;  pc_in = 16'h0126;
      tick();
      instr_ready_in = 1'b0;  fetch_req_in = 1'b0;
      check("t4_b2b_req",  {15'd0, mem_rd_req_out}, 16'd1);
      check("t4_b2b_addr", mem_addr_out, 16'h0126);
      check("t4_b2b_nv",   {15'd0, instr_valid_out}, 16'd0);
      tick(); tick();
      check("t4_instr", instr_out, 16'h5678);
      check("t4_pc",    instr_pc_out, 16'h0126);
      instr_ready_in = 1'b1;
      tick();
      instr_ready_in = 1'b0;

      // flush in FETCH_HI with an ack: high byte must not be written
      pc_in = 16'h0124;  fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      tick();
      check("t5_in_hi", mem_addr_out, 16'h0125);
      flush_in = 1'b1;  fetch_req_in = 1'b1;
      tick();
      flush_in = 1'b0;  fetch_req_in = 1'b0;
      check("t5_idle", {13'd0, busy_out, instr_valid_out, fetch_err_out}, 16'd0);
      check("t5_instr", instr_out, 16'h5634);
      tick();
      check("t5_after", {13'd0, busy_out, instr_valid_out, fetch_err_out}, 16'd0);

      // timeout with TIMEOUT=3: request held 4 cycles, then one error pulse
      no_ack = 1'b1;
      fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("t6_req_%0d", c), {14'd0, mem_rd_req_out, fetch_err_out}, 16'd2);
         tick();
      end
      check("t6_err", {13'd0, mem_rd_req_out, busy_out, fetch_err_out}, 16'd1);
      check("t6_instr", instr_out, 16'h5634);
      tick();
      check("t6_err_pulse", {15'd0, fetch_err_out}, 16'd0);

      // retry, then asynchronous reset mid-fetch
      fetch_req_in = 1'b1;
      tick();
      fetch_req_in = 1'b0;
      check("t7_req", {15'd0, mem_rd_req_out}, 16'd1);
      #2;
      reset_in = 1'b1;
      #1;
      check("t7_req_rst",   {15'd0, mem_rd_req_out}, 16'd0);
      check("t7_ctl_rst",   {13'd0, instr_valid_out, busy_out, fetch_err_out}, 16'd0);
      check("t7_addr_rst",  mem_addr_out, 16'h0000);
      check("t7_instr_rst", instr_out, 16'h0000);
      check("t7_pc_rst",    instr_pc_out, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetches one 16-bit instruction per request from a byte-wide instruction memory, at the halfword-aligned address supplied by the program counter. It sits directly downstream of the program counter and upstream of the decoder. It assembles the two bytes little-endian and holds the result in a single-entry buffer with a valid/ready handshake. Control logic uses `flush_in` to discard an in-flight fetch on jumps; a timeout guards against a memory that never acknowledges.

## Interface
Parameters:
- TIMEOUT, 15: maximum wait cycles per byte before the fetch is aborted; 0 disables the timeout. Counter width is $clog2(TIMEOUT+1), minimum 1.

Ports (reset reset_in, asynchronous, active-high; clock clk_in):
- clk_in  input  1  clock
- reset_in  input  1  asynchronous active-high reset
- pc_in  input  16  fetch address from program counter; bit 0 ignored
- fetch_req_in  input  1  request fetch of instruction at pc_in
- flush_in  input  1  abandon current fetch/buffered instruction
- mem_addr_out  output  16  byte address to instruction memory
- mem_rd_req_out  output  1  memory read request
- mem_ack_in  input  1  memory read acknowledge; mem_rdata_in valid this cycle
- mem_rdata_in  input  8  memory read data
- instr_out  output  16  fetched instruction
- instr_pc_out  output  16  address of instr_out, bit 0 = 0
- instr_valid_out  output  1  instr_out valid
- instr_ready_in  input  1  decoder accepts instruction
- busy_out  output  1  state != IDLE
- fetch_err_out  output  1  one-cycle pulse on timeout abort

## Operation
- FSM states are IDLE, FETCH_LO, FETCH_HI, VALID. Reset enters IDLE.
- IDLE, with fetch_req_in=1:
  - Latch addr_q <= pc_in[15:1].
  - Clear the wait counter.
  - Go to FETCH_LO.
- FETCH_LO:
  - mem_rd_req_out=1, mem_addr_out={addr_q,1'b0}.
  - On mem_ack_in: instr_q[7:0] <= mem_rdata_in, clear counter, go to FETCH_HI.
- FETCH_HI:
  - mem_rd_req_out=1, mem_addr_out={addr_q,1'b1}.
  - On mem_ack_in: instr_q[15:8] <= mem_rdata_in, go to VALID.
- VALID:
  - instr_valid_out=1; instr_out and instr_pc_out are held stable.
  - On instr_ready_in: if fetch_req_in is also 1, latch pc_in and go to FETCH_LO (back-to-back); otherwise go to IDLE.
- Outside FETCH states: mem_rd_req_out=0 and mem_addr_out holds its last value.
- Memory protocol:
  - mem_ack_in is honoured only while mem_rd_req_out=1; an ack in any other state is ignored.
  - The memory tolerates withdrawal of the request without an ack; there is no outstanding-transaction tracking.
- Wait counter:
  - Increments each FETCH_x cycle without ack.
  - If TIMEOUT!=0 and the counter == TIMEOUT with no ack in that cycle, abort: go to IDLE, fetch_err_out=1 for the next cycle, and do not update instr_q.
- Priority: reset_in > flush_in > ack > timeout.
  - An ack in the same cycle as counter==TIMEOUT completes normally.
- flush_in=1 in any state:
  - Next state is IDLE and instr_valid_out=0 next cycle.
  - Any same-cycle ack and fetch_req_in are ignored, and no error is raised.
- Reset values:
  - Outputs mem_addr_out, instr_out, instr_pc_out = 16'h0000; mem_rd_req_out, instr_valid_out, busy_out, fetch_err_out = 0.
  - Internal state is IDLE, counter 0.
- Reset mid-fetch drops mem_rd_req_out immediately (asynchronous).

## Timing
- fetch_req_in sampled at edge 0 → mem_rd_req_out high from cycle 1.
- With zero-wait memory (ack in the same cycle as the request): low byte at cycle 1, high byte at cycle 2, instr_valid_out=1 at cycle 3. Minimum latency is 3 cycles.
- Each memory wait cycle adds 1 cycle of latency.
- Sustained throughput with zero-wait memory and ready held high: 1 instruction per 3 cycles (VALID→FETCH_LO directly).
- instr_valid_out stays high indefinitely while instr_ready_in=0, with no change to instr_out.
- fetch_err_out is a single-cycle pulse, registered, asserted in the cycle after the timeout cycle.
- busy_out is combinational from the state register.

## Test plan
- Reset, then pc_in=16'h0124, fetch_req_in pulse:
  - Memory acks immediately with bytes 0x34 @0x0124 and 0x12 @0x0125.
  - Expect instr_out=16'h1234, instr_pc_out=16'h0124, valid at cycle 3.
- pc_in=16'h0125 (odd):
  - Expect mem_addr_out 0x0124 then 0x0125, instr_pc_out=16'h0124.
- Memory inserts 2 wait cycles per byte:
  - Expect valid at cycle 7; request and address stable during waits.
- Decoder holds instr_ready_in=0 for 5 cycles, then asserts it together with fetch_req_in and pc_in=16'h0126:
  - Expect instr_out held for 5 cycles, then immediate FETCH_LO at 0x0126.
- flush_in asserted in FETCH_HI coinciding with ack:
  - Expect IDLE next cycle, no instr_valid_out, instr_out unchanged, no fetch_err_out.
- TIMEOUT=3, memory never acks:
  - Expect mem_rd_req_out high for 4 cycles, then fetch_err_out pulse once and busy_out=0.
  - Then assert reset_in mid-fetch on a retry: all outputs return to 0 asynchronously.
